// File: rtl/sd_deserializer_frame.sv
// sd_deserializer_frame: serial-to-parallel frame receiver for the SD host
// CMD/DAT lines. Runtime frame length, optional start-bit hunting, selectable
// bit order and a valid/ready output handshake with sticky overflow.
// Optional CRC7/end-bit check: define SD_DESER_CRC7_EN to build it in.
module sd_deserializer_frame #(
    parameter int unsigned MAX_WIDTH    = 48,
    parameter int unsigned CNT_W        = 6,
    parameter bit          MSB_FIRST    = 1'b1,
    parameter bit          START_DETECT = 1'b1
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 serial,
    input  logic [CNT_W-1:0]     frame_len,
    output logic [MAX_WIDTH-1:0] parallel,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 overflow,
    output logic                 crc_ok
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_WIDTH);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     eff_len;
    logic [MAX_WIDTH-1:0] shift_q, shift_d;
    logic                 start_cond;
    logic                 done;

    // A frame may open only on an enabled cycle, and only on a start bit when hunting
    assign start_cond = enable && (!START_DETECT || !serial);

    // Out-of-range length requests fall back to the full parallel width
    always_comb begin
        eff_len = frame_len;
        if (frame_len == '0 || frame_len > LEN_MAX) begin
            eff_len = LEN_MAX;
        end
    end

    // FSM state register
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bit capture and frame-completion decode
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        shift_d = shift_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_cond) begin
                    // First bit always lands in position 0 of a cleared register
                    len_d   = eff_len;
                    shift_d = {{(MAX_WIDTH-1){1'b0}}, serial};
                    count_d = CNT_W'(1);
                    if (eff_len == CNT_W'(1)) begin
                        done    = 1'b1;
                        count_d = '0;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    // MSB-first shifts up so the frame ends right-aligned;
                    // LSB-first writes each bit directly at its final index
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[MAX_WIDTH-2:0], serial};
                    end else begin
                        shift_d[count_q] = serial;
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_d == len_q) begin
                        done    = 1'b1;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath registers: bit counter, latched length, shift register
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            len_q   <= '0;
            shift_q <= '0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
            shift_q <= shift_d;
        end
    end

`ifdef SD_DESER_CRC7_EN
    logic [6:0]       crc_q, crc_d;
    logic [7:0]       tail_q, tail_d;
    logic [CNT_W-1:0] len_act;
    logic             take_bit;
    logic             crc_bit;
    logic             crc_ok_d;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // CRC over bits 1..L-8; tail keeps the last 8 bits in arrival order
    // so the CRC field and end bit line up independent of MSB_FIRST
    always_comb begin
        crc_d    = crc_q;
        tail_d   = tail_q;
        len_act  = (state_q == ST_IDLE) ? eff_len : len_q;
        take_bit = (state_q == ST_IDLE) ? start_cond : enable;
        crc_bit  = ({4'b0, count_q} + (CNT_W+4)'(9)) <= {4'b0, len_act};
        if (take_bit) begin
            if (state_q == ST_IDLE) begin
                crc_d  = crc_bit ? crc7_step(7'h00, serial) : 7'h00;
                tail_d = {7'h00, serial};
            end else begin
                if (crc_bit) begin
                    crc_d = crc7_step(crc_q, serial);
                end
                tail_d = {tail_q[6:0], serial};
            end
        end
        crc_ok_d = (len_act >= CNT_W'(9)) && (tail_d[7:1] == crc_d) && tail_d[0];
    end

    // CRC accumulator and trailing-bit window
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            crc_q  <= '0;
            tail_q <= '0;
        end else begin
            crc_q  <= crc_d;
            tail_q <= tail_d;
        end
    end
`endif

    // Output register: load on completion unless an unconsumed frame blocks it
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            parallel <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            crc_ok   <= 1'b0;
        end else begin
            busy <= (state_d == ST_SHIFT);
`ifndef SD_DESER_CRC7_EN
            crc_ok <= 1'b1;
`endif
            if (valid && ready) begin
                valid    <= 1'b0;
                overflow <= 1'b0;
            end
            if (done) begin
                if (!valid || ready) begin
                    parallel <= shift_d;
                    valid    <= 1'b1;
`ifdef SD_DESER_CRC7_EN
                    crc_ok   <= crc_ok_d;
`endif
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_deserializer_frame.sv
// Bench for sd_deserializer_frame: one MSB-first start-hunting instance and
// one LSB-first free-running instance, scoreboard of expected frames.
module tb_sd_deserializer_frame;

    logic        sd_clock;
    logic        reset;
    logic        enable, serial, ready;
    logic [5:0]  frame_len;
    logic [47:0] parallel;
    logic        valid, busy, overflow, crc_ok;

    logic        en2, ser2, ready2;
    logic [5:0]  frame_len2;
    logic [47:0] parallel2;
    logic        valid2, busy2, overflow2, crc_ok2;

    typedef struct {
        logic [47:0] data;
        logic        crc;
    } frame_t;

    frame_t sb1[$];
    frame_t sb2[$];
    frame_t exp;
    int     tests = 0;
    int     fails = 0;

    sd_deserializer_frame #(
        .MAX_WIDTH(48), .CNT_W(6), .MSB_FIRST(1'b1), .START_DETECT(1'b1)
    ) dut (
        .sd_clock(sd_clock), .reset(reset), .enable(enable), .serial(serial),
        .frame_len(frame_len), .parallel(parallel), .valid(valid), .ready(ready),
        .busy(busy), .overflow(overflow), .crc_ok(crc_ok)
    );

    sd_deserializer_frame #(
        .MAX_WIDTH(48), .CNT_W(6), .MSB_FIRST(1'b0), .START_DETECT(1'b0)
    ) dut2 (
        .sd_clock(sd_clock), .reset(reset), .enable(en2), .serial(ser2),
        .frame_len(frame_len2), .parallel(parallel2), .valid(valid2), .ready(ready2),
        .busy(busy2), .overflow(overflow2), .crc_ok(crc_ok2)
    );

    initial begin
        sd_clock = 1'b0;
        forever #5 sd_clock = ~sd_clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Expected CRC7/end-bit result for frame d of length len in the given order
    function automatic logic crc_expect(input logic [47:0] d, input int len, input bit msb);
`ifdef SD_DESER_CRC7_EN
        logic [6:0] c  = 7'h00;
        logic [6:0] rx = 7'h00;
        logic       b, fb;
        if (len < 9) return 1'b0;
        for (int i = 1; i <= len - 8; i++) begin
            b  = msb ? d[len-i] : d[i-1];
            fb = c[6] ^ b;
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        for (int i = len - 7; i <= len - 1; i++) begin
            b  = msb ? d[len-i] : d[i-1];
            rx = {rx[5:0], b};
        end
        b = msb ? d[0] : d[len-1];
        return (rx == c) && b;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive1(input logic b);
        @(negedge sd_clock);
        enable = 1'b1;
        serial = b;
    endtask

    task automatic drive2(input logic b);
        @(negedge sd_clock);
        en2  = 1'b1;
        ser2 = b;
    endtask

    task automatic send1(input logic [47:0] d, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) drive1(d[i]);
    endtask

    task automatic send2(input logic [47:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive2(d[i]);
    endtask

    task automatic test_reset();
        #2;
        tests++; if (parallel !== 48'h0) begin fails++; $display("FAIL rst_parallel: got %h want 0", parallel); end
        tests++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_valid_busy: got %b%b want 00", valid, busy); end
        tests++; if (overflow !== 1'b0 || crc_ok !== 1'b0) begin fails++; $display("FAIL rst_ovf_crc: got %b%b want 00", overflow, crc_ok); end
        tests++; if (valid2 !== 1'b0 || parallel2 !== 48'h0) begin fails++; $display("FAIL rst_dut2: got %b %h want 0 0", valid2, parallel2); end
        @(negedge sd_clock);
        reset = 1'b1;
        @(negedge sd_clock);
        tests++; if (valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rel_idle: got %b%b want 00", valid, busy); end
`ifdef SD_DESER_CRC7_EN
        tests++; if (crc_ok !== 1'b0) begin fails++; $display("FAIL rel_crc_ok: got %b want 0", crc_ok); end
`else
        tests++; if (crc_ok !== 1'b1) begin fails++; $display("FAIL rel_crc_ok: got %b want 1", crc_ok); end
`endif
    endtask

    task automatic test_cmd_frame();
        logic [47:0] d;
        d = 48'h400000000095;
        frame_len = 6'd48;
        sb1.push_back('{data: d, crc: crc_expect(d, 48, 1'b1)});
        send1(d, 47, 1);
        @(negedge sd_clock);
        tests++; if (valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL cmd_bit47: valid/busy got %b%b want 01", valid, busy); end
        enable = 1'b1;
        serial = d[0];
        @(negedge sd_clock);
        enable = 1'b0;
        serial = 1'b1;
        exp = sb1.pop_front();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL cmd_valid: got %b want 1", valid); end
        tests++; if (parallel !== exp.data) begin fails++; $display("FAIL cmd_data: got %h want %h", parallel, exp.data); end
        tests++; if (crc_ok !== exp.crc) begin fails++; $display("FAIL cmd_crc: got %b want %b", crc_ok, exp.crc); end
        tests++; if (overflow !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL cmd_ovf_busy: got %b%b want 00", overflow, busy); end
        ready = 1'b1;
        @(negedge sd_clock);
        ready = 1'b0;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL cmd_consume: got %b want 0", valid); end
    endtask

    task automatic test_start_detect();
        logic [47:0] d;
        d = 48'h5A;
        frame_len = 6'd8;
        for (int i = 0; i < 10; i++) begin
            drive1(1'b1);
            @(posedge sd_clock);
            #1;
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sd_idle_busy%0d: got %b want 0", i, busy); end
        end
        sb1.push_back('{data: d, crc: crc_expect(d, 8, 1'b1)});
        drive1(d[7]);
        @(posedge sd_clock);
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sd_start_busy: got %b want 1", busy); end
        send1(d, 6, 0);
        @(negedge sd_clock);
        enable = 1'b0;
        exp = sb1.pop_front();
        tests++; if (valid !== 1'b1 || parallel !== exp.data) begin fails++; $display("FAIL sd_frame: got %b %h want 1 %h", valid, parallel, exp.data); end
        tests++; if (crc_ok !== exp.crc) begin fails++; $display("FAIL sd_crc: got %b want %b", crc_ok, exp.crc); end
        ready = 1'b1;
        @(negedge sd_clock);
        ready = 1'b0;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL sd_consume: got %b want 0", valid); end
    endtask

    task automatic test_simultaneous();
        logic [47:0] a, b;
        a = 48'h22;
        b = 48'h11;
        frame_len = 6'd8;
        sb1.push_back('{data: a, crc: crc_expect(a, 8, 1'b1)});
        sb1.push_back('{data: b, crc: crc_expect(b, 8, 1'b1)});
        send1(a, 7, 0);
        @(negedge sd_clock);
        enable = 1'b0;
        exp = sb1.pop_front();
        tests++; if (valid !== 1'b1 || parallel !== exp.data) begin fails++; $display("FAIL sim_first: got %b %h want 1 %h", valid, parallel, exp.data); end
        send1(b, 7, 1);
        @(negedge sd_clock);
        enable = 1'b1;
        serial = b[0];
        ready  = 1'b1;
        @(negedge sd_clock);
        enable = 1'b0;
        ready  = 1'b0;
        exp = sb1.pop_front();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL sim_valid: got %b want 1", valid); end
        tests++; if (parallel !== exp.data) begin fails++; $display("FAIL sim_data: got %h want %h", parallel, exp.data); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL sim_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_reset_midframe();
        logic [47:0] d;
        frame_len = 6'd48;
        d = {1'b0, 15'($urandom), $urandom};
        send1(d, 47, 28);
        @(negedge sd_clock);
        tests++; if (busy !== 1'b1 || valid !== 1'b1) begin fails++; $display("FAIL rmf_pre: busy/valid got %b%b want 11", busy, valid); end
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        tests++; if (parallel !== 48'h0 || valid !== 1'b0) begin fails++; $display("FAIL rmf_clear: got %h %b want 0 0", parallel, valid); end
        tests++; if (busy !== 1'b0 || overflow !== 1'b0 || crc_ok !== 1'b0) begin fails++; $display("FAIL rmf_flags: got %b%b%b want 000", busy, overflow, crc_ok); end
        @(negedge sd_clock);
        reset = 1'b1;
        d = {1'b0, 15'($urandom), $urandom};
        sb1.push_back('{data: d, crc: crc_expect(d, 48, 1'b1)});
        send1(d, 47, 0);
        @(negedge sd_clock);
        enable = 1'b0;
        exp = sb1.pop_front();
        tests++; if (valid !== 1'b1 || parallel !== exp.data) begin fails++; $display("FAIL rmf_next: got %b %h want 1 %h", valid, parallel, exp.data); end
        tests++; if (crc_ok !== exp.crc) begin fails++; $display("FAIL rmf_crc: got %b want %b", crc_ok, exp.crc); end
        ready = 1'b1;
        @(negedge sd_clock);
        ready = 1'b0;
    endtask

    task automatic test_lsb_first();
        int          lens[5] = '{0, 5, 50, 1, 9};
        int          l;
        logic [47:0] d, mask;
        for (int k = 0; k < 5; k++) begin
            frame_len2 = 6'(lens[k]);
            l = (lens[k] == 0 || lens[k] > 48) ? 48 : lens[k];
            mask = (l == 48) ? 48'hFFFF_FFFF_FFFF : ((48'd1 << l) - 48'd1);
            d = {16'($urandom), $urandom} & mask;
            sb2.push_back('{data: d, crc: crc_expect(d, l, 1'b0)});
            send2(d, 0, l - 1);
            @(negedge sd_clock);
            en2 = 1'b0;
            exp = sb2.pop_front();
            tests++; if (valid2 !== 1'b1 || parallel2 !== exp.data) begin fails++; $display("FAIL lsb_len%0d: got %b %h want 1 %h", lens[k], valid2, parallel2, exp.data); end
            tests++; if (crc_ok2 !== exp.crc || busy2 !== 1'b0) begin fails++; $display("FAIL lsb_flags%0d: crc/busy got %b%b want %b0", lens[k], crc_ok2, busy2, exp.crc); end
            ready2 = 1'b1;
            @(negedge sd_clock);
            ready2 = 1'b0;
            tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL lsb_consume%0d: got %b want 0", lens[k], valid2); end
        end
    endtask

    task automatic test_pause();
        logic [47:0] d;
        d = 48'hA5;
        frame_len2 = 6'd8;
        sb2.push_back('{data: d, crc: crc_expect(d, 8, 1'b0)});
        send2(d, 0, 3);
        @(negedge sd_clock);
        en2 = 1'b0;
        repeat (3) @(negedge sd_clock);
        tests++; if (busy2 !== 1'b1 || valid2 !== 1'b0) begin fails++; $display("FAIL pause_hold: busy/valid got %b%b want 10", busy2, valid2); end
        send2(d, 4, 6);
        @(negedge sd_clock);
        tests++; if (valid2 !== 1'b0) begin fails++; $display("FAIL pause_bit7: got %b want 0", valid2); end
        en2  = 1'b1;
        ser2 = d[7];
        @(negedge sd_clock);
        en2 = 1'b0;
        exp = sb2.pop_front();
        tests++; if (valid2 !== 1'b1 || parallel2 !== exp.data) begin fails++; $display("FAIL pause_frame: got %b %h want 1 %h", valid2, parallel2, exp.data); end
        ready2 = 1'b1;
        @(negedge sd_clock);
        ready2 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [47:0] a, b, held;
        a = 48'h3C;
        b = 48'hC3;
        frame_len2 = 6'd8;
        ready2 = 1'b0;
        sb2.push_back('{data: a, crc: crc_expect(a, 8, 1'b0)});
        send2(a, 0, 7);
        @(negedge sd_clock);
        en2 = 1'b0;
        exp = sb2.pop_front();
        held = exp.data;
        tests++; if (valid2 !== 1'b1 || parallel2 !== exp.data || overflow2 !== 1'b0) begin fails++; $display("FAIL bp_first: got %b %h %b want 1 %h 0", valid2, parallel2, overflow2, exp.data); end
        send2(b, 0, 7);
        @(negedge sd_clock);
        en2 = 1'b0;
        tests++; if (parallel2 !== held || valid2 !== 1'b1) begin fails++; $display("FAIL bp_held: got %b %h want 1 %h", valid2, parallel2, held); end
        tests++; if (overflow2 !== 1'b1) begin fails++; $display("FAIL bp_ovf: got %b want 1", overflow2); end
        repeat (2) @(negedge sd_clock);
        tests++; if (overflow2 !== 1'b1) begin fails++; $display("FAIL bp_ovf_sticky: got %b want 1", overflow2); end
        ready2 = 1'b1;
        @(negedge sd_clock);
        ready2 = 1'b0;
        tests++; if (valid2 !== 1'b0 || overflow2 !== 1'b0) begin fails++; $display("FAIL bp_clear: valid/ovf got %b%b want 00", valid2, overflow2); end
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        serial     = 1'b1;
        ready      = 1'b0;
        frame_len  = 6'd48;
        en2        = 1'b0;
        ser2       = 1'b0;
        ready2     = 1'b0;
        frame_len2 = 6'd8;
        test_reset();
        test_cmd_frame();
        test_start_detect();
        test_simultaneous();
        test_reset_midframe();
        test_lsb_first();
        test_pause();
        test_backpressure();
        tests++; if (sb1.size() != 0 || sb2.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d/%0d entries want 0/0", sb1.size(), sb2.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
